// File: rtl/i2s2_tx_serializer_if.sv
// ============================================================================
// Module   : i2s2_tx_serializer_if
// Brief    : Sample-pair valid/ready handshake between register block and
//            the I2S transmit serializer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface i2s2_tx_serializer_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_left;
    logic [DATA_WIDTH-1:0] s_right;

    modport master (
        output s_valid,
        output s_left,
        output s_right,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_left,
        input  s_right,
        output s_ready
    );
endinterface

`default_nettype wire

// File: rtl/i2s2_tx_serializer.sv
// ============================================================================
// Module   : i2s2_tx_serializer
// Brief    : Philips-I2S transmitter for the Pmod I2S2 DAC with a 2-entry
//            sample-pair FIFO and underflow accounting.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2s2_tx_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int SCLK_DIV   = 4
) (
    input  wire logic               ACLK,
    input  wire logic               ARESETN,
    input  wire logic               en,
    i2s2_tx_serializer_if.slave     s_if,
    output logic                    sclk,
    output logic                    lrck,
    output logic                    sdout,
    output logic                    frame_start,
    output logic                    underflow,
    output logic [15:0]             underflow_cnt,
    output logic [1:0]              fifo_level
);

    localparam int                 c_DIV_W    = $clog2(SCLK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam int                 c_SHIFT    = 31 - DATA_WIDTH;

    logic [c_DIV_W-1:0]             div_cnt_q,     div_cnt_d;
    logic                           sclk_q,        sclk_d;
    logic [5:0]                     bit_cnt_q,     bit_cnt_d;
    logic                           lrck_q,        lrck_d;
    logic                           sdout_q,       sdout_d;
    logic [DATA_WIDTH-1:0]          left_act_q,    left_act_d;
    logic [DATA_WIDTH-1:0]          right_act_q,   right_act_d;
    logic [1:0][DATA_WIDTH-1:0]     fifo_l_q,      fifo_l_d;
    logic [1:0][DATA_WIDTH-1:0]     fifo_r_q,      fifo_r_d;
    logic [1:0]                     level_q,       level_d;
    logic                           s_ready_q,     s_ready_d;
    logic                           frame_start_q, frame_start_d;
    logic                           underflow_q,   underflow_d;
    logic [15:0]                    underflow_cnt_q, underflow_cnt_d;

    logic                  w_tick;
    logic                  w_fall;
    logic                  w_wrap;
    logic                  w_push;
    logic                  w_pop;
    logic [1:0]            w_level_popped;
    logic [5:0]            w_bit_next;
    logic [DATA_WIDTH-1:0] w_word;
    logic [31:0]           w_slot_img;
    logic                  w_sdout_next;

    assign w_tick     = (div_cnt_q == c_DIV_LAST);
    assign w_fall     = w_tick & sclk_q;
    assign w_wrap     = w_fall & (bit_cnt_q == 6'd63);
    assign w_push     = s_if.s_valid & s_ready_q;
    assign w_pop      = w_wrap & (level_q != 2'd0);
    assign w_level_popped = level_q - {1'b0, w_pop};

    // Slot image: bit 31 is slot 0, word MSB lands in slot 1, tail slots are zero.
    assign w_bit_next   = bit_cnt_q + 6'd1;
    assign w_word       = w_bit_next[5] ? right_act_q : left_act_q;
    assign w_slot_img   = 32'(w_word) << c_SHIFT;
    assign w_sdout_next = w_slot_img[5'd31 - w_bit_next[4:0]];

    always_comb begin
        div_cnt_d       = div_cnt_q;
        sclk_d          = sclk_q;
        bit_cnt_d       = bit_cnt_q;
        lrck_d          = lrck_q;
        sdout_d         = sdout_q;
        left_act_d      = left_act_q;
        right_act_d     = right_act_q;
        fifo_l_d        = fifo_l_q;
        fifo_r_d        = fifo_r_q;
        level_d         = level_q;
        s_ready_d       = s_ready_q;
        frame_start_d   = 1'b0;
        underflow_d     = 1'b0;
        underflow_cnt_d = underflow_cnt_q;

        if (!en) begin
            div_cnt_d   = '0;
            sclk_d      = 1'b0;
            bit_cnt_d   = 6'd63;
            lrck_d      = 1'b0;
            sdout_d     = 1'b0;
            left_act_d  = '0;
            right_act_d = '0;
            level_d     = 2'd0;
            s_ready_d   = 1'b0;
        end else begin
            div_cnt_d = w_tick ? '0 : div_cnt_q + c_DIV_ONE;
            sclk_d    = sclk_q ^ w_tick;

            if (w_fall) begin
                bit_cnt_d = w_bit_next;
                lrck_d    = w_bit_next[5];
                sdout_d   = w_sdout_next;
            end

            if (w_wrap) begin
                frame_start_d = 1'b1;
                if (level_q != 2'd0) begin
                    left_act_d  = fifo_l_q[0];
                    right_act_d = fifo_r_q[0];
                end else begin
                    left_act_d  = '0;
                    right_act_d = '0;
                    underflow_d = 1'b1;
                    if (underflow_cnt_q != 16'hFFFF) begin
                        underflow_cnt_d = underflow_cnt_q + 16'd1;
                    end
                end
            end

            // Pop shifts the tail forward first so a simultaneous push lands behind it.
            if (w_pop) begin
                fifo_l_d[0] = fifo_l_q[1];
                fifo_r_d[0] = fifo_r_q[1];
            end
            if (w_push) begin
                if (w_level_popped == 2'd0) begin
                    fifo_l_d[0] = s_if.s_left;
                    fifo_r_d[0] = s_if.s_right;
                end else begin
                    fifo_l_d[1] = s_if.s_left;
                    fifo_r_d[1] = s_if.s_right;
                end
            end
            level_d   = w_level_popped + {1'b0, w_push};
            s_ready_d = (level_d != 2'd2);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            div_cnt_q       <= '0;
            sclk_q          <= 1'b0;
            bit_cnt_q       <= 6'd63;
            lrck_q          <= 1'b0;
            sdout_q         <= 1'b0;
            left_act_q      <= '0;
            right_act_q     <= '0;
            fifo_l_q        <= '0;
            fifo_r_q        <= '0;
            level_q         <= 2'd0;
            s_ready_q       <= 1'b0;
            frame_start_q   <= 1'b0;
            underflow_q     <= 1'b0;
            underflow_cnt_q <= 16'd0;
        end else begin
            div_cnt_q       <= div_cnt_d;
            sclk_q          <= sclk_d;
            bit_cnt_q       <= bit_cnt_d;
            lrck_q          <= lrck_d;
            sdout_q         <= sdout_d;
            left_act_q      <= left_act_d;
            right_act_q     <= right_act_d;
            fifo_l_q        <= fifo_l_d;
            fifo_r_q        <= fifo_r_d;
            level_q         <= level_d;
            s_ready_q       <= s_ready_d;
            frame_start_q   <= frame_start_d;
            underflow_q     <= underflow_d;
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    assign s_if.s_ready  = s_ready_q;
    assign sclk          = sclk_q;
    assign lrck          = lrck_q;
    assign sdout         = sdout_q;
    assign frame_start   = frame_start_q;
    assign underflow     = underflow_q;
    assign underflow_cnt = underflow_cnt_q;
    assign fifo_level    = level_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s2_tx_serializer.sv
// ============================================================================
// Module   : tb_i2s2_tx_serializer
// Brief    : Directed self-checking bench for the I2S transmit serializer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2s2_tx_serializer;

    localparam int DW = 24;

    logic        ACLK    = 1'b0;
    logic        ARESETN = 1'b0;
    logic        en      = 1'b0;
    logic        sclk, lrck, sdout, frame_start, underflow;
    logic [15:0] underflow_cnt;
    logic [1:0]  fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    i2s2_tx_serializer_if #(.DATA_WIDTH(DW)) s_if ();

    i2s2_tx_serializer #(.DATA_WIDTH(DW), .SCLK_DIV(4)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .en            (en),
        .s_if          (s_if),
        .sclk          (sclk),
        .lrck          (lrck),
        .sdout         (sdout),
        .frame_start   (frame_start),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt),
        .fifo_level    (fifo_level)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (frame_start !== 1'b1 && n < 1000);
        check("frame_start_seen", frame_start, 1'b1);
    endtask

    // Entered just after a frame-start edge; leaves at the next frame start.
    task automatic capture(output logic [63:0] f, output int bad);
        f   = '0;
        bad = 0;
        for (int j = 0; j < 64; j++) begin
            if (sclk !== 1'b0 || lrck !== (j >= 32)) bad++;
            step(4);
            f[j] = sdout;
            if (sclk !== 1'b1 || frame_start !== 1'b0 || underflow !== 1'b0) bad++;
            step(4);
        end
    endtask

    function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] f;
        f = '0;
        for (int k = 1; k <= 24; k++) begin
            f[k]      = l[24-k];
            f[32 + k] = r[24-k];
        end
        return f;
    endfunction

    initial begin
        logic [63:0] fr;
        logic [23:0] pl [3];
        logic [23:0] pr [3];
        logic        rdy;
        int          bad, cyc, n, idx, stall;

        s_if.s_valid = 1'b0;
        s_if.s_left  = '0;
        s_if.s_right = '0;
        pl = '{24'h123456, 24'h800001, 24'h7FFFFE};
        pr = '{24'hABCDEF, 24'h000FFF, 24'hFFF000};

        #12;
        check("reset_outs", {sclk, lrck, sdout, s_if.s_ready, fifo_level, frame_start,
                             underflow, underflow_cnt}, '0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        step(3);
        check("idle_outs", {s_if.s_ready, sclk, frame_start}, '0);

        // Single pair, enable-to-frame latency and bit layout
        en  = 1'b1;
        cyc = 0;
        step(1); cyc++;
        check("ready_after_en", s_if.s_ready, 1'b1);
        s_if.s_valid = 1'b1;
        s_if.s_left  = 24'hA5A5A5;
        s_if.s_right = 24'h5A5A5A;
        step(1); cyc++;
        s_if.s_valid = 1'b0;
        check("level_after_push", fifo_level, 2'd1);
        wait_fs(n);
        cyc += n;
        check("en_to_frame_start", cyc, 8);
        check("t2_pop", {fifo_level, underflow}, '0);
        capture(fr, bad);
        check("t2_frame", fr, exp_frame(24'hA5A5A5, 24'h5A5A5A));
        check("t2_timing", bad, 0);

        // Three empty frames
        for (int f = 1; f <= 3; f++) begin
            check("t4_uf_pulse", {frame_start, underflow}, 2'b11);
            check("t4_uf_cnt", underflow_cnt, f);
            if (f < 3) begin
                capture(fr, bad);
                check("t4_zero_frame", fr, '0);
                check("t4_timing", bad, 0);
            end
        end

        // Back-to-back pushes: two fit, third waits for the pop
        idx   = 0;
        stall = 0;
        cyc   = 0;
        s_if.s_valid = 1'b1;
        s_if.s_left  = pl[0];
        s_if.s_right = pr[0];
        do begin
            rdy = s_if.s_ready;
            step(1);
            cyc++;
            if (rdy && idx < 3) begin
                idx++;
                if (idx < 3) begin
                    s_if.s_left  = pl[idx];
                    s_if.s_right = pr[idx];
                end
            end
            if (idx >= 2 && s_if.s_ready === 1'b1 && frame_start !== 1'b1) stall++;
        end while (frame_start !== 1'b1 && cyc < 1000);
        check("t3_fs_seen", frame_start, 1'b1);
        check("t3_accepted_before_pop", idx, 2);
        check("t3_no_ready_when_full", stall, 0);
        check("t3_after_pop", {fifo_level, s_if.s_ready, underflow}, {2'd1, 1'b1, 1'b0});
        capture(fr, bad);
        s_if.s_valid = 1'b0;
        check("t3_frame1", fr, exp_frame(pl[0], pr[0]));
        check("t3_level_with_third", fifo_level, 2'd1);
        capture(fr, bad);
        check("t3_frame2", fr, exp_frame(pl[1], pr[1]));
        capture(fr, bad);
        check("t3_frame3", fr, exp_frame(pl[2], pr[2]));
        check("t3_timing", bad, 0);
        check("t3_then_uf", {frame_start, underflow, underflow_cnt}, {2'b11, 16'd4});

        // Drop enable at bit_cnt 40 with one pair queued
        s_if.s_valid = 1'b1;
        s_if.s_left  = 24'hC0FFEE;
        s_if.s_right = 24'h0BEEF0;
        step(1);
        s_if.s_valid = 1'b0;
        step(323);
        check("t5_mid_state", {sclk, lrck, fifo_level}, {2'b11, 2'd1});
        en = 1'b0;
        step(1);
        check("t5_idle_pins", {sclk, lrck, sdout, fifo_level, s_if.s_ready, frame_start,
                               underflow}, '0);
        step(20);
        check("t5_idle_hold", {sclk, lrck, sdout, fifo_level, s_if.s_ready, underflow,
                               underflow_cnt}, {7'b0, 16'd4});
        en  = 1'b1;
        cyc = 0;
        step(1); cyc++;
        s_if.s_valid = 1'b1;
        s_if.s_left  = 24'h3C3C3C;
        s_if.s_right = 24'hC3C3C3;
        step(1); cyc++;
        s_if.s_valid = 1'b0;
        wait_fs(n);
        cyc += n;
        check("t5_reen_latency", cyc, 8);
        check("t5_reen_no_uf", underflow, 1'b0);
        capture(fr, bad);
        check("t5_frame", fr, exp_frame(24'h3C3C3C, 24'hC3C3C3));
        check("t5_timing", bad, 0);
        check("t5_then_uf", {frame_start, underflow, underflow_cnt}, {2'b11, 16'd5});

        // Asynchronous reset between clock edges
        s_if.s_valid = 1'b1;
        s_if.s_left  = 24'h111111;
        s_if.s_right = 24'h222222;
        step(1);
        s_if.s_valid = 1'b0;
        step(299);
        check("t1_pre_reset", {sclk, lrck, fifo_level}, {2'b11, 2'd1});
        #2;
        ARESETN = 1'b0;
        #1;
        check("t1_async_reset", {sclk, lrck, sdout, s_if.s_ready, fifo_level, underflow_cnt}, '0);

        // Saturation of the underflow counter
        @(negedge ACLK);
        ARESETN = 1'b1;
        force dut.underflow_cnt_q = 16'hFFFE;
        #1;
        release dut.underflow_cnt_q;
        for (int f = 0; f < 3; f++) begin
            wait_fs(n);
            check("t6_uf_pulse", underflow, 1'b1);
            check("t6_cnt_sat", underflow_cnt, 16'hFFFF);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
